// File: rtl/stress_load_scheduler.sv
// Stress-fabric load scheduler: ramps the stress banks on one at a time,
// holds a plateau, then ramps them off again. This bounds di/dt on the core rail.
// An alarm sheds the whole load on the next edge.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, stop         run launch pulse / orderly ramp-down request
//   alarm               level; immediate shed, blocks start while high
//   target_level        plateau bank count (latched on start, clamped)
//   step_cycles         cycles per ramp step (latched on start, min 1)
//   hold_cycles         plateau length (latched on start, 0 acts as 1)
//   bank_en             registered thermometer enables, bank_en[i] = (i < level)
//   level               number of enabled banks
//   state               IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4
//   busy, done          state decodes (registered)
//   aborted             sticky alarm flag, cleared by an accepted start
//   active_cycles       saturating count of cycles with level > 0
module stress_load_scheduler #(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned LVL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 alarm,
    input  logic [LVL_W-1:0]     target_level,
    input  logic [15:0]          step_cycles,
    input  logic [31:0]          hold_cycles,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic [LVL_W-1:0]     level,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [31:0]          active_cycles
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned ACT_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD      = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LVL_W-1:0]     tgt_q, tgt_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic [LVL_W-1:0]     level_d;
    logic                 aborted_d;
    logic [ACT_W-1:0]     active_d;
    logic [NUM_BANKS-1:0] bank_en_d;
    logic                 busy_d, done_d;

    logic [LVL_W-1:0]     tgt_in;
    logic [STEP_W-1:0]    step_in;
    logic                 step_hit, hold_hit;

    // Config sanitising applied at latch time
    assign tgt_in  = (target_level > LVL_W'(NUM_BANKS)) ? LVL_W'(NUM_BANKS) : target_level;
    assign step_in = (step_cycles == '0) ? STEP_W'(1) : step_cycles;

    // Terminal-count compares against latched config only
    assign step_hit = (cnt_q == (CNT_W'(step_q) - CNT_W'(1)));
    assign hold_hit = (hold_q == '0) ? (cnt_q == '0) : (cnt_q == (hold_q - CNT_W'(1)));

    assign state = state_q;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        level_d   = level;
        cnt_d     = cnt_q + CNT_W'(1);
        tgt_d     = tgt_q;
        step_d    = step_q;
        hold_d    = hold_q;
        aborted_d = aborted;
        active_d  = active_cycles;
        bank_en_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        if ((level != '0) && (active_cycles != '1)) begin
            active_d = active_cycles + ACT_W'(1);
        end

        if (alarm) begin
            // Shed overrides everything; in IDLE it only flags and blocks start
            aborted_d = 1'b1;
            cnt_d     = '0;
            if (state_q != S_IDLE) begin
                state_d = S_DONE;
                level_d = '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    cnt_d = '0;
                    if (start) begin
                        tgt_d     = tgt_in;
                        step_d    = step_in;
                        hold_d    = hold_cycles;
                        aborted_d = 1'b0;
                        active_d  = '0;
                        level_d   = '0;
                        state_d   = (tgt_in != '0) ? S_RAMP_UP : S_DONE;
                    end
                end
                S_RAMP_UP: begin
                    if (stop) begin
                        state_d = S_RAMP_DOWN;
                    end else if (step_hit) begin
                        cnt_d   = '0;
                        level_d = level + LVL_W'(1);
                        if (level_d == tgt_q) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (stop || hold_hit) begin
                        state_d = S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    // A stop issued before the first step lands here at level 0
                    if (level == '0) begin
                        state_d = S_DONE;
                    end else if (step_hit) begin
                        cnt_d   = '0;
                        level_d = level - LVL_W'(1);
                        if (level_d == '0) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    level_d = '0;
                end
            endcase
        end

        // Counter restarts on every state entry
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            bank_en_d[i] = (i < 32'(level_d));
        end
        busy_d = (state_d == S_RAMP_UP) || (state_d == S_HOLD) || (state_d == S_RAMP_DOWN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tgt_q         <= '0;
            step_q        <= STEP_W'(1);
            hold_q        <= '0;
            level         <= '0;
            bank_en       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            active_cycles <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            step_q        <= step_d;
            hold_q        <= hold_d;
            level         <= level_d;
            bank_en       <= bank_en_d;
            busy          <= busy_d;
            done          <= done_d;
            aborted       <= aborted_d;
            active_cycles <= active_d;
        end
    end

endmodule
